// File: rtl/dump_pkg.sv
// ---------------------------------------------------------------------------
// dump_pkg
// Shared types and default widths for the data-memory dump streamer.
//   dump_state_t : FSM encoding used by dmem_dump_streamer
//   DUMP_ADDR_W  : default data-memory address width
//   DUMP_DATA_W  : default data-memory word width
// ---------------------------------------------------------------------------
package dump_pkg;

   typedef enum logic [1:0] {
      IDLE,
      FETCH,
      SEND,
      FIN
   } dump_state_t;

   localparam int DUMP_ADDR_W = 8;
   localparam int DUMP_DATA_W = 8;

endpackage

// File: rtl/dmem_dump_streamer.sv
// ---------------------------------------------------------------------------
// dmem_dump_streamer
// After the core signals completion, this block takes over the data-memory
// read port and walks the address window [START_ADDR, END_ADDR]. Each byte is
// emitted on a valid/ready stream together with its address and a last-beat
// flag. An 8-bit modular checksum of accepted bytes is kept for the host.
//
// Ports:
//   clk          in   system clock, shared with the core
//   reset        in   synchronous, active-high reset
//   done         in   core completion flag (a one-cycle pulse is enough)
//   mem_sel      out  1 = this block drives the data-memory address port
//   mem_addr     out  data-memory read address
//   mem_rd_data  in   asynchronous read data for mem_addr
//   out_valid    out  stream beat valid
//   out_ready    in   sink accepts the beat
//   out_data     out  dumped byte
//   out_addr     out  address of out_data
//   out_last     out  beat carries END_ADDR
//   checksum     out  running sum of accepted bytes (carry discarded)
//   dump_done    out  sticky completion flag
// ---------------------------------------------------------------------------
module dmem_dump_streamer
   import dump_pkg::*;
#(
   parameter int ADDR_W     = DUMP_ADDR_W,
   parameter int DATA_W     = DUMP_DATA_W,
   parameter int START_ADDR = 0,
   parameter int END_ADDR   = 255
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              done,
   output logic              mem_sel,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_rd_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [ADDR_W-1:0] out_addr,
   output logic              out_last,
   output logic [DATA_W-1:0] checksum,
   output logic              dump_done
);

   // An inverted window would never reach END_ADDR, so refuse to build it.
   if (START_ADDR > END_ADDR) begin : g_bad_window
      $error("dmem_dump_streamer: START_ADDR must not exceed END_ADDR");
   end

   localparam logic [ADDR_W-1:0] StartA = ADDR_W'(START_ADDR);
   localparam logic [ADDR_W-1:0] EndA   = ADDR_W'(END_ADDR);

   dump_state_t       state_q;
   logic [ADDR_W-1:0] cnt_q;
   logic              mem_sel_q;
   logic [ADDR_W-1:0] mem_addr_q;
   logic              out_valid_q;
   logic [DATA_W-1:0] out_data_q;
   logic [ADDR_W-1:0] out_addr_q;
   logic              out_last_q;
   logic [DATA_W-1:0] checksum_q;
   logic              dump_done_q;

   // Single FSM process. The memory address is registered one cycle ahead of
   // the capture edge, so FETCH sees valid read data from the async memory.
   // The END comparison is made on the current address before any increment,
   // which keeps the counter from wrapping when END_ADDR is the top address.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         cnt_q       <= StartA;
         mem_sel_q   <= 1'b0;
         mem_addr_q  <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_addr_q  <= '0;
         out_last_q  <= 1'b0;
         checksum_q  <= '0;
         dump_done_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               mem_sel_q  <= 1'b0;
               mem_addr_q <= '0;
               if (done) begin
                  state_q    <= FETCH;
                  mem_sel_q  <= 1'b1;
                  mem_addr_q <= cnt_q;
               end
            end
            FETCH: begin
               out_data_q  <= mem_rd_data;
               out_addr_q  <= cnt_q;
               out_last_q  <= (cnt_q == EndA);
               out_valid_q <= 1'b1;
               state_q     <= SEND;
            end
            SEND: begin
               if (out_valid_q && out_ready) begin
                  checksum_q  <= checksum_q + out_data_q;
                  out_valid_q <= 1'b0;
                  if (out_last_q) begin
                     state_q     <= FIN;
                     mem_sel_q   <= 1'b0;
                     mem_addr_q  <= '0;
                     out_last_q  <= 1'b0;
                     dump_done_q <= 1'b1;
                  end else begin
                     cnt_q      <= cnt_q + ADDR_W'(1);
                     mem_addr_q <= cnt_q + ADDR_W'(1);
                     state_q    <= FETCH;
                  end
               end
            end
            FIN: begin
               // Terminal until reset; done is deliberately ignored here.
               mem_sel_q   <= 1'b0;
               out_valid_q <= 1'b0;
               out_last_q  <= 1'b0;
               dump_done_q <= 1'b1;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign mem_sel   = mem_sel_q;
   assign mem_addr  = mem_addr_q;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_addr  = out_addr_q;
   assign out_last  = out_last_q;
   assign checksum  = checksum_q;
   assign dump_done = dump_done_q;

endmodule

// File: tb/tb_dmem_dump_streamer.sv
// ---------------------------------------------------------------------------
// tb_dmem_dump_streamer
// Two streamer instances: dutA dumps window 0..3, dutB dumps the single
// address 255. Expected beats for dutA are queued when a dump is started and
// popped by a monitor on every accepted beat.
// ---------------------------------------------------------------------------
module tb_dmem_dump_streamer;

   typedef struct {
      logic [7:0] addr;
      logic [7:0] data;
      logic       last;
   } beat_t;

   logic       clk;
   logic       reset;

   logic       doneA, memSelA, outValidA, outReadyA, outLastA, dumpDoneA;
   logic [7:0] memAddrA, memRdA, outDataA, outAddrA, checksumA;

   logic       doneB, memSelB, outValidB, outReadyB, outLastB, dumpDoneB;
   logic [7:0] memAddrB, memRdB, outDataB, outAddrB, checksumB;

   logic [7:0] memA [256];
   logic [7:0] memB [256];

   beat_t      sbQ[$];
   int         checkCount = 0;
   int         failCount  = 0;
   logic [7:0] sumModel;

   // Asynchronous memory models feeding each instance.
   assign memRdA = memA[memAddrA];
   assign memRdB = memB[memAddrB];

   dmem_dump_streamer #(.ADDR_W(8), .DATA_W(8), .START_ADDR(0), .END_ADDR(3)) dutA (
      .clk(clk), .reset(reset), .done(doneA),
      .mem_sel(memSelA), .mem_addr(memAddrA), .mem_rd_data(memRdA),
      .out_valid(outValidA), .out_ready(outReadyA), .out_data(outDataA),
      .out_addr(outAddrA), .out_last(outLastA), .checksum(checksumA),
      .dump_done(dumpDoneA)
   );

   dmem_dump_streamer #(.ADDR_W(8), .DATA_W(8), .START_ADDR(255), .END_ADDR(255)) dutB (
      .clk(clk), .reset(reset), .done(doneB),
      .mem_sel(memSelB), .mem_addr(memAddrB), .mem_rd_data(memRdB),
      .out_valid(outValidB), .out_ready(outReadyB), .out_data(outDataB),
      .out_addr(outAddrB), .out_last(outLastB), .checksum(checksumB),
      .dump_done(dumpDoneB)
   );

   // Free-running clock, 10 time units per period.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Every comparison in the bench goes through here.
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   // Queue the expected beats of dutA's window, then pulse done for one cycle.
   // Returns #1 after the edge that samples done.
   task automatic applyStimulus();
      beat_t b;
      for (int a = 0; a <= 3; a++) begin
         b.addr = 8'(a);
         b.data = memA[a];
         b.last = (a == 3);
         sbQ.push_back(b);
      end
      sumModel = 8'h00;
      doneA = 1'b1;
      @(posedge clk); #1;
      doneA = 1'b0;
   endtask

   task automatic resetDut();
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   // Bounded wait for dutA completion; cycles counted from the call point.
   task automatic waitDumpDone(input string tag, output int cyc);
      cyc = 0;
      while (!dumpDoneA && cyc < 60) begin
         @(posedge clk); #1;
         cyc++;
      end
      if (!dumpDoneA) checkOutput(tag, 32'd0, 32'd1);
   endtask

   // Scoreboard monitor: every accepted beat must match the head of the queue.
   // While a beat is stalled it must still match the head (held stable).
   always @(negedge clk) begin : monitor
      beat_t e;
      if (!reset && outValidA) begin
         if (sbQ.size() == 0) begin
            checkOutput("beat_extra", 32'd1, 32'd0);
         end else begin
            e = sbQ[0];
            checkOutput("beat_addr", 32'(outAddrA), 32'(e.addr));
            checkOutput("beat_data", 32'(outDataA), 32'(e.data));
            checkOutput("beat_last", 32'(outLastA), 32'(e.last));
            if (outReadyA) begin
               void'(sbQ.pop_front());
               sumModel = sumModel + e.data;
            end
         end
      end
   end

   initial begin : mainSeq
      int cyc;
      int beats;

      reset     = 1'b1;
      doneA     = 1'b0;
      doneB     = 1'b0;
      outReadyA = 1'b1;
      outReadyB = 1'b0;
      for (int i = 0; i < 256; i++) begin
         memA[i] = 8'hAA;
         memB[i] = 8'h55;
      end
      memA[0] = 8'h10; memA[1] = 8'h20; memA[2] = 8'h30; memA[3] = 8'hF5;
      memB[255] = 8'h7F;
      memB[0]   = 8'hEE;

      // Reset hold: done stays low, everything idle.
      resetDut();
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         if (i % 5 == 0) begin
            checkOutput("hold_mem_sel", 32'(memSelA), 32'd0);
            checkOutput("hold_valid", 32'(outValidA), 32'd0);
            checkOutput("hold_checksum", 32'(checksumA), 32'd0);
            checkOutput("hold_dump_done", 32'(dumpDoneA), 32'd0);
            checkOutput("hold_mem_addr", 32'(memAddrA), 32'd0);
            checkOutput("hold_B_mem_sel", 32'(memSelB), 32'd0);
         end
      end

      // Full stream with a single-cycle done pulse.
      applyStimulus();
      checkOutput("fetch_valid", 32'(outValidA), 32'd0);
      checkOutput("fetch_mem_sel", 32'(memSelA), 32'd1);
      checkOutput("fetch_mem_addr", 32'(memAddrA), 32'd0);
      @(posedge clk); #1;
      checkOutput("first_valid", 32'(outValidA), 32'd1);
      waitDumpDone("full_timeout", cyc);
      checkOutput("full_done_latency", 32'(cyc + 1), 32'd8);
      checkOutput("full_checksum", 32'(checksumA), 32'h55);
      checkOutput("full_checksum_model", 32'(checksumA), 32'(sumModel));
      checkOutput("full_sb_empty", 32'(sbQ.size()), 32'd0);
      checkOutput("full_mem_sel_fin", 32'(memSelA), 32'd0);

      // Backpressure on beat 1 for five cycles.
      resetDut();
      applyStimulus();
      cyc = 0;
      while (!(outValidA && outAddrA == 8'd1) && cyc < 20) begin
         @(posedge clk); #1;
         cyc++;
      end
      checkOutput("bp_reach_beat1", 32'(outAddrA), 32'd1);
      outReadyA = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         checkOutput("bp_valid", 32'(outValidA), 32'd1);
         checkOutput("bp_addr", 32'(outAddrA), 32'd1);
         checkOutput("bp_data", 32'(outDataA), 32'h20);
      end
      outReadyA = 1'b1;
      waitDumpDone("bp_timeout", cyc);
      checkOutput("bp_checksum", 32'(checksumA), 32'h55);
      checkOutput("bp_sb_empty", 32'(sbQ.size()), 32'd0);

      // Single-byte window on dutB at the top address.
      doneB = 1'b1;
      @(posedge clk); #1;
      doneB = 1'b0;
      checkOutput("single_mem_addr", 32'(memAddrB), 32'd255);
      cyc = 0;
      while (!outValidB && cyc < 10) begin
         @(posedge clk); #1;
         cyc++;
      end
      checkOutput("single_valid", 32'(outValidB), 32'd1);
      checkOutput("single_addr", 32'(outAddrB), 32'd255);
      checkOutput("single_data", 32'(outDataB), 32'h7F);
      checkOutput("single_last", 32'(outLastB), 32'd1);
      outReadyB = 1'b1;
      beats = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (outValidB && outReadyB) beats++;
         @(posedge clk); #1;
      end
      checkOutput("single_beats", 32'(beats), 32'd1);
      checkOutput("single_checksum", 32'(checksumB), 32'h7F);
      checkOutput("single_dump_done", 32'(dumpDoneB), 32'd1);
      checkOutput("single_mem_sel", 32'(memSelB), 32'd0);

      // Reset in the middle of the dump, while beat 2 is offered.
      resetDut();
      applyStimulus();
      cyc = 0;
      while (!(outValidA && outAddrA == 8'd2) && cyc < 20) begin
         @(posedge clk); #1;
         cyc++;
      end
      checkOutput("mid_reach_beat2", 32'(outAddrA), 32'd2);
      reset = 1'b1;
      @(posedge clk); #1;
      checkOutput("mid_mem_sel", 32'(memSelA), 32'd0);
      checkOutput("mid_mem_addr", 32'(memAddrA), 32'd0);
      checkOutput("mid_valid", 32'(outValidA), 32'd0);
      checkOutput("mid_data", 32'(outDataA), 32'd0);
      checkOutput("mid_addr", 32'(outAddrA), 32'd0);
      checkOutput("mid_last", 32'(outLastA), 32'd0);
      checkOutput("mid_checksum", 32'(checksumA), 32'd0);
      checkOutput("mid_dump_done", 32'(dumpDoneA), 32'd0);
      sbQ.delete();
      reset = 1'b0;
      @(posedge clk); #1;
      applyStimulus();
      checkOutput("restart_mem_addr", 32'(memAddrA), 32'd0);
      waitDumpDone("restart_timeout", cyc);
      checkOutput("restart_checksum", 32'(checksumA), 32'h55);
      checkOutput("restart_sb_empty", 32'(sbQ.size()), 32'd0);

      // Post-completion: toggling done must not start anything.
      for (int i = 0; i < 10; i++) begin
         doneA = ~doneA;
         @(posedge clk); #1;
         checkOutput("post_valid", 32'(outValidA), 32'd0);
         checkOutput("post_mem_sel", 32'(memSelA), 32'd0);
         checkOutput("post_dump_done", 32'(dumpDoneA), 32'd1);
      end
      doneA = 1'b0;
      checkOutput("post_checksum", 32'(checksumA), 32'h55);

      $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
      $finish;
   end

endmodule
